// File: rtl/pipearch_common_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipearch_common (package)
// Description : Definitions shared by the pipeline-architecture stages:
//               prefetch sizing and the write-stage state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pipearch_common;

  // Input buffering is sized to cover one prefetch burst of lines.
  localparam int LOG2_PREFETCH_SIZE = 4;

  // Write-stage operation states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } t_writestate;

endpackage
`default_nettype wire

// File: rtl/fifobram_interface.sv
`default_nettype none
// ============================================================================
// Module      : fifobram_interface
// Description : Connection bundle between a line FIFO and its consumer.
//               Read data is valid the cycle after re.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifobram_interface #(
  parameter int WIDTH = 512
);
  logic             we;
  logic [WIDTH-1:0] wdata;
  logic             re;
  logic             rvalid;
  logic [WIDTH-1:0] rdata;
  logic             empty;
  logic             almostfull;
  logic             overflow;

  modport fifo (
    input  we, wdata, re,
    output rvalid, rdata, empty, almostfull, overflow
  );
endinterface
`default_nettype wire

// File: rtl/pipearch_commonwrite_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pipearch_commonwrite_fifo
// Description : Common line FIFO with one-cycle read latency, registered
//               almost-full flag and sticky overflow flag. Pushes while full
//               are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module pipearch_commonwrite_fifo #(
  parameter int          WIDTH      = 512,
  parameter int          LOG2_DEPTH = 4,
  parameter int unsigned AF_MARGIN  = 4
) (
  input logic             clk,
  input logic             reset_n,
  fifobram_interface.fifo bus
);

  localparam int unsigned C_DEPTH    = 32'd1 << LOG2_DEPTH;
  localparam int unsigned C_AF_LEVEL = C_DEPTH - AF_MARGIN;

  logic [WIDTH-1:0]      r_mem [C_DEPTH];
  logic [LOG2_DEPTH-1:0] r_wptr;
  logic [LOG2_DEPTH-1:0] r_rptr;
  logic [LOG2_DEPTH:0]   r_count;
  logic [LOG2_DEPTH:0]   w_count_next;
  logic [WIDTH-1:0]      r_rdata;
  logic                  r_rvalid;
  logic                  r_almostfull;
  logic                  r_overflow;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  // Count can never exceed the depth, so its top bit alone marks full.
  assign w_full  = r_count[LOG2_DEPTH];
  assign w_empty = (r_count == '0);
  assign w_push  = bus.we && !w_full;
  assign w_pop   = bus.re && !w_empty;

  // Occupancy after this cycle; push and pop together leave it unchanged.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + (LOG2_DEPTH+1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - (LOG2_DEPTH+1)'(1);
    end
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_rvalid     <= 1'b0;
      r_almostfull <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + LOG2_DEPTH'(1);
      if (w_pop)  r_rptr <= r_rptr + LOG2_DEPTH'(1);
      r_count      <= w_count_next;
      r_rvalid     <= w_pop;
      // Flag from the next count so the producer sees it the cycle after the
      // push that crossed the threshold.
      r_almostfull <= (32'(w_count_next) >= C_AF_LEVEL);
      if (bus.we && w_full) r_overflow <= 1'b1;
    end
  end

  // Storage array and registered read port; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.wdata;
    if (w_pop)  r_rdata       <= r_mem[r_rptr];
  end

  assign bus.rvalid     = r_rvalid;
  assign bus.rdata      = r_rdata;
  assign bus.empty      = w_empty;
  assign bus.almostfull = r_almostfull;
  assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire

// File: rtl/pipearch_commonwrite.sv
`default_nettype none
// ============================================================================
// Module      : pipearch_commonwrite
// Description : Write stage: buffers lines from the load stage and writes
//               regs1 of them to local memory starting at line offset regs0,
//               then pulses op_done.
// Revision    : 1.0 - initial release
// ============================================================================
module pipearch_commonwrite
  import pipearch_common::*;
#(
  parameter int WIDTH           = 512,
  parameter int LOG2_MEM_DEPTH  = 10,
  parameter int LOG2_FIFO_DEPTH = LOG2_PREFETCH_SIZE,
  parameter int AF_MARGIN       = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      op_start,
  output logic                      op_done,
  input  logic [31:0]               regs0,
  input  logic [31:0]               regs1,
  input  logic                      in_we,
  input  logic [WIDTH-1:0]          in_wdata,
  output logic                      in_almostfull,
  input  logic                      mem_busy,
  output logic                      mem_we,
  output logic [LOG2_MEM_DEPTH-1:0] mem_waddr,
  output logic [WIDTH-1:0]          mem_wdata,
  output logic                      overflow_err
);

  t_writestate r_state;
  t_writestate w_state_next;

  logic [31:0]               r_base;
  logic [31:0]               r_length;
  logic [31:0]               r_popped;
  logic [31:0]               r_written;
  logic                      r_mem_we;
  logic [LOG2_MEM_DEPTH-1:0] r_mem_waddr;
  logic [WIDTH-1:0]          r_mem_wdata;
  logic                      r_op_done;

  logic w_start;
  logic w_pop;
  logic w_issue;
  logic w_finish;

  fifobram_interface #(.WIDTH(WIDTH)) u_fifo_bus ();

  pipearch_commonwrite_fifo #(
    .WIDTH      (WIDTH),
    .LOG2_DEPTH (LOG2_FIFO_DEPTH),
    .AF_MARGIN  (AF_MARGIN)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_fifo_bus)
  );

  // Lines are buffered in every state: load may start in the same cycle.
  assign u_fifo_bus.we    = in_we;
  assign u_fifo_bus.wdata = in_wdata;
  assign u_fifo_bus.re    = w_pop;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next state: a zero-length op completes directly; otherwise leave WRITE
  // as the final line's write is issued.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (op_start) w_state_next = (regs1 == 32'd0) ? DONE : WRITE;
      WRITE:   if (w_issue && (r_written == r_length - 32'd1)) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Per-state controls; in-flight reads are written even if mem_busy rises.
  always_comb begin
    w_start  = (r_state == IDLE) && op_start;
    w_pop    = (r_state == WRITE) && !u_fifo_bus.empty && !mem_busy &&
               (r_popped < r_length);
    w_issue  = (r_state == WRITE) && u_fifo_bus.rvalid;
    w_finish = (r_state == DONE);
  end

  // Operation registers, counters and write/done strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base    <= '0;
      r_length  <= '0;
      r_popped  <= '0;
      r_written <= '0;
      r_mem_we  <= 1'b0;
      r_op_done <= 1'b0;
    end else begin
      r_mem_we  <= w_issue;
      r_op_done <= w_finish;
      if (w_start) begin
        r_base    <= regs0;
        r_length  <= regs1;
        r_popped  <= '0;
        r_written <= '0;
      end else begin
        if (w_pop)   r_popped  <= r_popped + 32'd1;
        if (w_issue) r_written <= r_written + 32'd1;
      end
    end
  end

  // Address and data are only meaningful alongside mem_we; address wraps
  // modulo the memory depth.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_mem_waddr <= LOG2_MEM_DEPTH'(r_base + r_written);
      r_mem_wdata <= u_fifo_bus.rdata;
    end
  end

  assign op_done       = r_op_done;
  assign mem_we        = r_mem_we;
  assign mem_waddr     = r_mem_waddr;
  assign mem_wdata     = r_mem_wdata;
  assign in_almostfull = u_fifo_bus.almostfull;
  assign overflow_err  = u_fifo_bus.overflow;

endmodule
`default_nettype wire

// File: doc/pipearch_commonwrite.md
PIPEARCH_COMMONWRITE -- requirements
Module: pipearch_commonwrite

Interface
REQ-001 SHALL have parameter WIDTH, default 512, meaning the line width in bits.
REQ-002 SHALL have parameter LOG2_MEM_DEPTH, default 10, meaning the local memory address width.
REQ-003 SHALL have parameter LOG2_FIFO_DEPTH, default LOG2_PREFETCH_SIZE, meaning the input buffer depth exponent.
REQ-004 SHALL have parameter AF_MARGIN, default 4, meaning the free slots left when almostfull asserts.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port op_start, input, 1 bit: a one-cycle command strobe.
REQ-008 SHALL have port op_done, output, 1 bit: a one-cycle completion pulse.
REQ-009 SHALL have port regs0, input, 32 bits: the base line offset in local memory.
REQ-010 SHALL have port regs1, input, 32 bits: the number of lines to write.
REQ-011 SHALL have port in_we, input, 1 bit: the line-valid strobe from the load stage.
REQ-012 SHALL have port in_wdata, input, WIDTH bits: the line data from the load stage.
REQ-013 SHALL have port in_almostfull, output, 1 bit: backpressure to the load stage.
REQ-014 SHALL have port mem_busy, input, 1 bit: the local memory port is claimed by another user.
REQ-015 SHALL have port mem_we, output, 1 bit: the local memory write enable.
REQ-016 SHALL have port mem_waddr, output, LOG2_MEM_DEPTH bits: the local memory write address.
REQ-017 SHALL have port mem_wdata, output, WIDTH bits: the local memory write data.
REQ-018 SHALL have port overflow_err, output, 1 bit: a sticky flag for input lines lost on a full buffer.

Function
REQ-019 SHALL push every in_we line into the input FIFO in any state, including IDLE, because load and write start in the same cycle.
REQ-020 SHALL register in_almostfull high when FIFO count >= 2^LOG2_FIFO_DEPTH - AF_MARGIN.
REQ-021 SHALL drop in_we while the FIFO is full and set overflow_err until reset.
REQ-022 SHALL implement states IDLE, WRITE and DONE, with IDLE being the reset state.
REQ-023 SHALL, in IDLE on op_start, latch base=regs0 and length=regs1, clear the popped/written counters, and go to DONE if regs1==0, else to WRITE.
REQ-024 SHALL, in WRITE, pop the FIFO in a cycle only when it is non-empty, mem_busy is 0, and popped < length.
REQ-025 SHALL, for each popped word, register mem_we=1, mem_wdata=word and mem_waddr=(base+written) truncated to LOG2_MEM_DEPTH bits (wrap modulo memory depth) two cycles after the pop; mem_busy does not cancel an in-flight word.
REQ-026 SHALL increment written on each mem_we and move WRITE->DONE in the cycle the write with written==length-1 is issued.
REQ-027 SHALL, in DONE, pulse op_done for exactly one cycle and return to IDLE; total latency from last pop to op_done is 3 cycles.
REQ-028 SHALL ignore op_start outside IDLE.
REQ-029 SHALL leave surplus FIFO lines beyond length in the FIFO for the next operation.
REQ-030 SHALL accept simultaneous FIFO push and pop in one cycle with no count change.
REQ-031 SHALL use 32-bit unsigned arithmetic for counters and base addition, with truncation only at mem_waddr.

Reset
REQ-032 SHALL, on reset_n low, immediately drive op_done=0, mem_we=0, in_almostfull=0 and overflow_err=0, go to IDLE, clear counters and empty the FIFO.
REQ-033 SHALL, when reset is asserted mid-operation, issue no memory write after reset is asserted and no op_done for the aborted operation.
REQ-034 SHALL leave mem_waddr and mem_wdata at don't-care while mem_we=0.

Structure
REQ-035 SHALL take LOG2_PREFETCH_SIZE and the t_writestate enum (IDLE/WRITE/DONE) from the shared package pipearch_common.
REQ-036 SHALL instantiate exactly one sub-module, the common fifo, through fifobram_interface, with a one-cycle read latency (rvalid the cycle after re).

Verification
REQ-037 SHALL verify basic: regs0=8, regs1=4, four lines D0..D3 on consecutive cycles -> mem_we at addresses 8..11 with D0..D3, first write 3 cycles after the first in_we, then op_done one cycle after the last write.
REQ-038 SHALL verify zero length: op_start with regs1=0 -> op_done 2 cycles later, no mem_we, and FIFO contents untouched.
REQ-039 SHALL verify wrap: regs0=1022, regs1=4, LOG2_MEM_DEPTH=10 -> addresses 1022, 1023, 0, 1.
REQ-040 SHALL verify backpressure: mem_busy=1 held, 16-deep FIFO, AF_MARGIN=4, 20 lines offered while the driver honours almostfull -> almostfull after 12 lines, no overflow; after mem_busy=0, all lines are written in order.
REQ-041 SHALL verify overflow and reset: 17 lines into a full 16-deep FIFO -> overflow_err=1; reset_n pulsed low mid-WRITE -> outputs clear at once, and a subsequent op with regs1=2 completes normally.
